// File: rtl/multi_cycle_control.sv
// multi_cycle_control -- multi-cycle LEGv8 control unit (FETCH/DECODE/EXEC/MEM/WB).
// Optional build macro: MCC_ILLEGAL_TRAP_EN. When it is defined, an illegal opcode
// parks the FSM in TRAP with Illegal=1 until reset. Otherwise the instruction is
// skipped with a PC update.
// A shared wait counter bounds MemReady stalls in FETCH and MEM (MEM_TIMEOUT, 0 = off).
module multi_cycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TIMEOUT_W   = 4
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [10:0] Opcode,
  input  logic        MemReady,
  output logic        IMemRead,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic        Uncondbranch,
  output logic [1:0]  ALUOp,
  output logic [2:0]  State,
  output logic        MemErr,
  output logic        Illegal
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  // Instruction classes latched in DECODE.
  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_RTYPE = 3'd1;
  localparam logic [2:0] C_LDUR  = 3'd2;
  localparam logic [2:0] C_STUR  = 3'd3;
  localparam logic [2:0] C_CBZ   = 3'd4;
  localparam logic [2:0] C_B     = 3'd5;
  localparam logic [2:0] C_ILL   = 3'd6;

  logic [2:0]           state, state_nxt;
  logic [2:0]           cls, dec_cls;
  logic                 run;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 in_wait, timeout;

  // Classify the opcode currently on the bus.
  always_comb begin
    casez (Opcode)
      11'b11111000010: dec_cls = C_LDUR;
      11'b11111000000: dec_cls = C_STUR;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: dec_cls = C_RTYPE;
      11'b10110100???: dec_cls = C_CBZ;
      11'b000101?????: dec_cls = C_B;
      default:         dec_cls = C_ILL;
    endcase
  end

  assign in_wait = run && (state == S_FETCH || state == S_MEM);
  // A ready strobe in the same cycle always beats the timeout.
  assign timeout = in_wait && !MemReady && (MEM_TIMEOUT != 0) &&
                   (wait_cnt == TIMEOUT_W'(MEM_TIMEOUT));

  // Next-state selection; nothing moves until the first edge after reset release.
  always_comb begin
    state_nxt = state;
    if (run) begin
      case (state)
        S_FETCH:  if (MemReady) state_nxt = S_DECODE;
        S_DECODE: begin
          if (dec_cls == C_ILL) begin
`ifdef MCC_ILLEGAL_TRAP_EN
            state_nxt = S_TRAP;
`else
            state_nxt = S_FETCH;
`endif
          end else begin
            state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls)
            C_RTYPE:        state_nxt = S_WB;
            C_LDUR, C_STUR: state_nxt = S_MEM;
            default:        state_nxt = S_FETCH;
          endcase
        end
        S_MEM: begin
          if (MemReady)     state_nxt = (cls == C_LDUR) ? S_WB : S_FETCH;
          else if (timeout) state_nxt = S_FETCH;
        end
        S_WB:    state_nxt = S_FETCH;
        S_TRAP:  state_nxt = S_TRAP;
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  // State, latched class, run flag and saturating wait counter.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state    <= S_FETCH;
      cls      <= C_NONE;
      run      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, so
      // the order of these statements cannot change the hardware.
      run   <= 1'b1;
      state <= state_nxt;
      if (run && state == S_DECODE) cls <= dec_cls;
      if (!in_wait || MemReady || timeout) wait_cnt <= '0;
      else if (wait_cnt != '1)             wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Moore control decode from state and latched class, plus the ready/timeout strobes.
  always_comb begin
    // NOTE: every output gets a default first; a path that skips an assignment
    // would otherwise infer a latch.
    IMemRead     = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    Reg2Loc      = 1'b0;
    ALUSrc       = 1'b0;
    MemToReg     = 1'b0;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    Branch       = 1'b0;
    Uncondbranch = 1'b0;
    ALUOp        = 2'b00;
    MemErr       = 1'b0;
    Illegal      = 1'b0;
    if (run) begin
      case (state)
        S_FETCH: begin
          IMemRead = 1'b1;
          IRWrite  = MemReady;
          MemErr   = timeout;
        end
        S_DECODE: begin
`ifndef MCC_ILLEGAL_TRAP_EN
          PCWrite = (dec_cls == C_ILL);
`endif
        end
        S_EXEC: begin
          case (cls)
            C_RTYPE: ALUOp = 2'b10;
            C_LDUR:  ALUSrc = 1'b1;
            C_STUR: begin
              ALUSrc  = 1'b1;
              Reg2Loc = 1'b1;
            end
            C_CBZ: begin
              Reg2Loc = 1'b1;
              ALUOp   = 2'b01;
              Branch  = 1'b1;
              PCWrite = 1'b1;
            end
            C_B: begin
              Uncondbranch = 1'b1;
              PCWrite      = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          ALUSrc   = 1'b1;
          MemRead  = (cls == C_LDUR);
          MemWrite = (cls == C_STUR);
          PCWrite  = (MemReady && cls == C_STUR) || timeout;
          MemErr   = timeout;
        end
        S_WB: begin
          RegWrite = 1'b1;
          MemToReg = (cls == C_LDUR);
          PCWrite  = 1'b1;
        end
        S_TRAP: begin
`ifdef MCC_ILLEGAL_TRAP_EN
          Illegal = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign State = state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control -- builds each instruction's expected cycle timeline from
// its class and chosen MemReady stall pattern, then drives and checks it cycle by cycle.
// Builds with or without MCC_ILLEGAL_TRAP_EN.
module tb_multi_cycle_control;

  localparam int MEM_TIMEOUT = 15;

  logic        CLK, Reset_L, MemReady;
  logic [10:0] Opcode;
  logic        IMemRead, IRWrite, PCWrite, Reg2Loc, ALUSrc, MemToReg, RegWrite;
  logic        MemRead, MemWrite, Branch, Uncondbranch, MemErr, Illegal;
  logic [1:0]  ALUOp;
  logic [2:0]  State;

  multi_cycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .TIMEOUT_W(4)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .Opcode(Opcode), .MemReady(MemReady),
    .IMemRead(IMemRead), .IRWrite(IRWrite), .PCWrite(PCWrite), .Reg2Loc(Reg2Loc),
    .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .Uncondbranch(Uncondbranch),
    .ALUOp(ALUOp), .State(State), .MemErr(MemErr), .Illegal(Illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic imr, irw, pcw, r2l, alusrc, m2r, rw, mr, mw, br, ub;
    logic [1:0] aluop;
    logic [2:0] st;
    logic err, ill;
  } ctl_t;

  typedef struct {
    logic        rdy;
    logic [10:0] opc;
    ctl_t        exp;
  } cyc_t;

  typedef enum int {K_LDUR, K_STUR, K_ADD, K_SUB, K_AND, K_ORR, K_CBZ, K_B, K_ILL} kind_t;

  ctl_t act;
  assign act = {IMemRead, IRWrite, PCWrite, Reg2Loc, ALUSrc, MemToReg, RegWrite,
                MemRead, MemWrite, Branch, Uncondbranch, ALUOp, State, MemErr, Illegal};

  cyc_t plan[$];
  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  int n_pcw, n_rw, n_mr, n_mw, n_err, n_br, n_ill;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic kind_t classify(input logic [10:0] opc);
    casez (opc)
      11'b11111000010: return K_LDUR;
      11'b11111000000: return K_STUR;
      11'b10001011000: return K_ADD;
      11'b11001011000: return K_SUB;
      11'b10001010000: return K_AND;
      11'b10101010000: return K_ORR;
      11'b10110100???: return K_CBZ;
      11'b000101?????: return K_B;
      default:         return K_ILL;
    endcase
  endfunction

  function automatic logic [10:0] mk_opc(input int k);
    logic [10:0] o;
    case (k)
      K_LDUR:  o = 11'b11111000010;
      K_STUR:  o = 11'b11111000000;
      K_ADD:   o = 11'b10001011000;
      K_SUB:   o = 11'b11001011000;
      K_AND:   o = 11'b10001010000;
      K_ORR:   o = 11'b10101010000;
      K_CBZ:   o = {8'b10110100, 3'($urandom)};
      K_B:     o = {6'b000101, 5'($urandom)};
      default: begin
        o = 11'($urandom);
        while (classify(o) != K_ILL) o = 11'($urandom);
      end
    endcase
    return o;
  endfunction

  function automatic void push(input logic rdy, input logic [10:0] opc, input ctl_t e);
    cyc_t c;
    c.rdy = rdy;
    c.opc = opc;
    c.exp = e;
    plan.push_back(c);
  endfunction

  // Expected timeline of one instruction: fw stall cycles before the fetch completes,
  // mw stall cycles before the data access completes (timeouts applied on the way).
  task automatic add_instr(input logic [10:0] opc, input int fw, input int mw);
    ctl_t  e;
    int    k;
    kind_t kd;
    kd = classify(opc);
    k  = 0;
    for (int i = 0; i < fw; i++) begin
      e = '0; e.imr = 1'b1;
      if (MEM_TIMEOUT != 0 && k == MEM_TIMEOUT) begin e.err = 1'b1; k = 0; end
      else k++;
      push(1'b0, 11'($urandom), e);
    end
    e = '0; e.imr = 1'b1; e.irw = 1'b1;
    push(1'b1, 11'($urandom), e);
    e = '0; e.st = 3'd1;
    if (kd == K_ILL) begin
`ifdef MCC_ILLEGAL_TRAP_EN
      push(1'($urandom), opc, e);
      for (int i = 0; i < 12; i++) begin
        e = '0; e.st = 3'd5; e.ill = 1'b1;
        push(1'($urandom), opc, e);
      end
`else
      e.pcw = 1'b1;
      push(1'($urandom), opc, e);
`endif
      return;
    end
    push(1'($urandom), opc, e);
    e = '0; e.st = 3'd2;
    case (kd)
      K_LDUR: e.alusrc = 1'b1;
      K_STUR: begin e.alusrc = 1'b1; e.r2l = 1'b1; end
      K_CBZ:  begin e.r2l = 1'b1; e.aluop = 2'b01; e.br = 1'b1; e.pcw = 1'b1; end
      K_B:    begin e.ub = 1'b1; e.pcw = 1'b1; end
      default: e.aluop = 2'b10;
    endcase
    push(1'($urandom), opc, e);
    if (kd == K_CBZ || kd == K_B) return;
    if (kd == K_LDUR || kd == K_STUR) begin
      k = 0;
      for (int i = 0; ; i++) begin
        e = '0; e.st = 3'd3; e.alusrc = 1'b1;
        e.mr = (kd == K_LDUR); e.mw = (kd == K_STUR);
        if (i == mw) begin
          e.pcw = (kd == K_STUR);
          push(1'b1, opc, e);
          if (kd == K_STUR) return;
          break;
        end
        if (MEM_TIMEOUT != 0 && k == MEM_TIMEOUT) begin
          e.err = 1'b1; e.pcw = 1'b1;
          push(1'b0, opc, e);
          return;
        end
        k++;
        push(1'b0, opc, e);
      end
    end
    e = '0; e.st = 3'd4; e.rw = 1'b1; e.pcw = 1'b1; e.m2r = (kd == K_LDUR);
    push(1'($urandom), opc, e);
  endtask

  task automatic clr_tally();
    n_pcw = 0; n_rw = 0; n_mr = 0; n_mw = 0; n_err = 0; n_br = 0; n_ill = 0;
  endtask

  // Drive and check up to n planned cycles; inputs change and outputs are sampled
  // in the low phase of the clock.
  task automatic run_n(input int n);
    cyc_t c;
    for (int i = 0; i < n && plan.size() > 0; i++) begin
      c = plan.pop_front();
      @(negedge CLK);
      MemReady = c.rdy;
      Opcode   = c.opc;
      #1;
      check($sformatf("cyc%0d_st%0d", ncyc, c.exp.st), 32'(act), 32'(c.exp));
      n_pcw += int'(PCWrite); n_rw += int'(RegWrite); n_mr += int'(MemRead);
      n_mw  += int'(MemWrite); n_err += int'(MemErr); n_br += int'(Branch);
      n_ill += int'(Illegal);
      ncyc++;
    end
  endtask

  task automatic run_all();
    run_n(plan.size());
  endtask

  // Assert reset away from a clock edge, hold it across edges, release on a negedge.
  task automatic do_reset(input string tag);
    Reset_L = 1'b0;
    #1;
    check({tag, "_async"}, 32'(act), 32'd0);
    plan.delete();
    MemReady = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check({tag, "_held"}, 32'(act), 32'd0);
    @(negedge CLK);
    Reset_L = 1'b1;
    #1;
    check({tag, "_pre_edge"}, 32'(act), 32'd0);
  endtask

  initial begin
    logic [11:0] st_seq;
    int          nk;
    Reset_L  = 1'b0;
    MemReady = 1'b0;
    Opcode   = '0;
    clr_tally();
    repeat (3) @(negedge CLK);
    #1;
    check("reset_outputs", 32'(act), 32'd0);
    @(negedge CLK);
    Reset_L = 1'b1;
    #1;
    check("release_pre_edge", 32'(act), 32'd0);

    // ADD with no stalls: 0,1,2,4 and a single PC update.
    add_instr(11'b10001011000, 0, 0);
    check("add_len", 32'(plan.size()), 32'd4);
    st_seq = {plan[0].exp.st, plan[1].exp.st, plan[2].exp.st, plan[3].exp.st};
    check("add_states", 32'(st_seq), 32'h054);
    clr_tally(); run_all();
    check("add_pcw", 32'(n_pcw), 32'd1);
    check("add_rw", 32'(n_rw), 32'd1);

    // LDUR with three stall cycles in MEM.
    add_instr(11'b11111000010, 0, 3);
    check("ldur_len", 32'(plan.size()), 32'd8);
    clr_tally(); run_all();
    check("ldur_mr", 32'(n_mr), 32'd4);
    check("ldur_rw", 32'(n_rw), 32'd1);

    // CBZ: three cycles, branch in EXEC, no register write.
    add_instr(11'b10110100101, 0, 0);
    check("cbz_len", 32'(plan.size()), 32'd3);
    clr_tally(); run_all();
    check("cbz_br", 32'(n_br), 32'd1);
    check("cbz_rw", 32'(n_rw), 32'd0);

    // STUR with MemReady stuck low: timeout in the 16th MEM cycle.
    add_instr(11'b11111000000, 0, 40);
    check("stur_to_len", 32'(plan.size()), 32'd19);
    clr_tally(); run_all();
    check("stur_to_err", 32'(n_err), 32'd1);
    check("stur_to_mw", 32'(n_mw), 32'd16);
    add_instr(11'b10001011000, 0, 0);
    clr_tally(); run_all();
    check("after_to_mw", 32'(n_mw), 32'd0);

    // Fetch timeout: refetch without a PC update.
    add_instr(11'b11001011000, 17, 0);
    check("fetch_to_len", 32'(plan.size()), 32'd21);
    clr_tally(); run_all();
    check("fetch_to_err", 32'(n_err), 32'd1);
    check("fetch_to_pcw", 32'(n_pcw), 32'd1);

    // Asynchronous reset in the middle of an LDUR stall.
    add_instr(11'b11111000010, 0, 10);
    run_n(5);
    #2;
    do_reset("rst_mid_mem");
    add_instr(11'b11111000000, 1, 1);
    add_instr(11'b10110100000, 0, 0);
    clr_tally(); run_all();
    check("post_rst_rw", 32'(n_rw), 32'd0);

    // Random instruction stream.
`ifdef MCC_ILLEGAL_TRAP_EN
    nk = 8;
`else
    nk = 9;
`endif
    for (int i = 0; i < 150; i++) begin
      int fw, mw;
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 4);
      add_instr(mk_opc($urandom_range(0, nk - 1)), fw, mw);
      run_all();
    end

    // Illegal opcode 00000000000.
    add_instr(11'b00000000000, 0, 0);
    clr_tally(); run_all();
`ifdef MCC_ILLEGAL_TRAP_EN
    check("ill_trap_cycles", 32'(n_ill), 32'd12);
    check("ill_trap_pcw", 32'(n_pcw), 32'd0);
    @(negedge CLK);
    #2;
    do_reset("rst_trap");
    add_instr(11'b10001010000, 0, 0);
    run_all();
`else
    check("ill_skip_pcw", 32'(n_pcw), 32'd1);
    check("ill_flag", 32'(n_ill), 32'd0);
    add_instr(11'b10101010000, 0, 0);
    run_all();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
